// File: rtl/stepper_seq_multi.sv
// Multi-channel stepper excitation sequencer: shared step timer, debounced mode button, host mode write.
// Optional build macro STEPPER_VREF_PWM_EN selects a 4-bit PWM on VREF instead of a static level.
module stepper_seq_multi #(
  parameter int         NUM_CH     = 2,
  parameter int         PERIOD_W   = 24,
  parameter int         DEBOUNCE   = 270000,
  parameter logic [1:0] MODE_RESET = 2'd0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sw_mode_n,
  input  logic                  mode_wr,
  input  logic [1:0]            mode_wdata,
  input  logic [PERIOD_W-1:0]   period_i,
  input  logic [NUM_CH-1:0]     dir_i,
  input  logic [NUM_CH-1:0]     enable_i,
  input  logic [4*NUM_CH-1:0]   vref_level_i,
  output logic [NUM_CH-1:0]     ina1_o,
  output logic [NUM_CH-1:0]     ina2_o,
  output logic [NUM_CH-1:0]     inb1_o,
  output logic [NUM_CH-1:0]     inb2_o,
  output logic [NUM_CH-1:0]     stanby_o,
  output logic [NUM_CH-1:0]     vref_o,
  output logic [1:0]            mode_o,
  output logic                  step_tick_o,
  output logic [3*NUM_CH-1:0]   phase_idx_o
);

  localparam int            DB_W    = $clog2(DEBOUNCE + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [1:0]    MODE_WAVE = 2'd0;
  localparam logic [1:0]    MODE_FULL = 2'd1;
  localparam logic [1:0]    MODE_HALF = 2'd2;
  localparam logic [1:0]    MODE_STBY = 2'd3;

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} db_state_t;

  logic                sw_meta;
  logic                sw_sync;
  db_state_t           db_state;
  logic [DB_W-1:0]     db_cnt;
  logic                press;
  logic [1:0]          pending;
  logic [PERIOD_W-1:0] cnt;
  logic                tick_now;
  logic [NUM_CH-1:0]   active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= 1'b1;
      sw_sync <= 1'b1;
    end else begin
      sw_meta <= sw_mode_n;
      sw_sync <= sw_meta;
    end
  end

  // Leaving a WAIT state on a toggle and re-entering it later restarts the count from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_state <= RELEASED;
      db_cnt   <= '0;
    end else begin
      case (db_state)
        RELEASED: begin
          if (!sw_sync) begin
            db_state <= PRESS_WAIT;
            db_cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (sw_sync)                db_state <= RELEASED;
          else if (db_cnt == DB_LAST) db_state <= PRESSED;
          else                        db_cnt   <= db_cnt + 1'b1;
        end
        PRESSED: begin
          if (sw_sync) begin
            db_state <= RELEASE_WAIT;
            db_cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (!sw_sync)               db_state <= PRESSED;
          else if (db_cnt == DB_LAST) db_state <= RELEASED;
          else                        db_cnt   <= db_cnt + 1'b1;
        end
        default: db_state <= RELEASED;
      endcase
    end
  end

  assign press    = (db_state == PRESS_WAIT) && !sw_sync && (db_cnt == DB_LAST);
  assign tick_now = (period_i != '0) && (cnt >= period_i - PERIOD_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= MODE_RESET;
      mode_o      <= MODE_RESET;
      cnt         <= '0;
      step_tick_o <= 1'b0;
    end else begin
      if (mode_wr)    pending <= mode_wdata;
      else if (press) pending <= pending + 2'd1;

      if (period_i == '0) begin
        cnt         <= '0;
        step_tick_o <= 1'b0;
        mode_o      <= pending;
      end else if (tick_now) begin
        cnt         <= '0;
        step_tick_o <= 1'b1;
        mode_o      <= pending;
      end else begin
        cnt         <= cnt + 1'b1;
        step_tick_o <= 1'b0;
      end
    end
  end

  // Stepping uses the mode taking effect on this tick, so bit0 is forced immediately.
  function automatic logic [2:0] next_idx(input logic [2:0] idx, input logic up,
                                          input logic [1:0] mode);
    logic [2:0] stp;
    logic [2:0] n;
    stp = (mode == MODE_HALF) ? 3'd1 : 3'd2;
    n   = up ? idx + stp : idx - stp;
    if (mode == MODE_WAVE) n[0] = 1'b0;
    if (mode == MODE_FULL) n[0] = 1'b1;
    return n;
  endfunction

  // Returns {ina1, ina2, inb1, inb2}.
  function automatic logic [3:0] coil_pattern(input logic [2:0] idx);
    logic [3:0] p;
    p = 4'b0000;
    case (idx)
      3'd0: p = 4'b1000;
      3'd1: p = 4'b1010;
      3'd2: p = 4'b0010;
      3'd3: p = 4'b0110;
      3'd4: p = 4'b0100;
      3'd5: p = 4'b0101;
      3'd6: p = 4'b0001;
      3'd7: p = 4'b1001;
      default: p = 4'b0000;
    endcase
    return p;
  endfunction

  always_comb begin
    active = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      active[c] = enable_i[c] && (mode_o != MODE_STBY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_idx_o <= '0;
      ina1_o      <= '0;
      ina2_o      <= '0;
      inb1_o      <= '0;
      inb2_o      <= '0;
      stanby_o    <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (tick_now && enable_i[c] && (pending != MODE_STBY)) begin
          phase_idx_o[3*c +: 3] <= next_idx(phase_idx_o[3*c +: 3], dir_i[c], pending);
        end
        {ina1_o[c], ina2_o[c], inb1_o[c], inb2_o[c]} <=
          active[c] ? coil_pattern(phase_idx_o[3*c +: 3]) : 4'b0000;
        stanby_o[c] <= active[c];
      end
    end
  end

`ifdef STEPPER_VREF_PWM_EN
  logic [3:0] pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm    <= '0;
      vref_o <= '0;
    end else begin
      pwm <= pwm + 4'd1;
      for (int c = 0; c < NUM_CH; c++) begin
        vref_o[c] <= active[c] && (pwm < vref_level_i[4*c +: 4]);
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vref_o <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        vref_o[c] <= active[c] && (|vref_level_i[4*c +: 4]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_stepper_seq_multi.sv
// Directed bench for stepper_seq_multi: table of half-step vectors plus hand-written mode/debounce/period sequences.
module tb_stepper_seq_multi;
  localparam int NCH = 2;
  localparam int PW  = 8;
  localparam int DB  = 6;
`ifdef STEPPER_VREF_PWM_EN
  localparam int VREF4_HIGH = 4;
`else
  localparam int VREF4_HIGH = 16;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sw_mode_n = 1'b1;
  logic            mode_wr = 1'b0;
  logic [1:0]      mode_wdata = 2'd0;
  logic [PW-1:0]   period = '0;
  logic [NCH-1:0]  dir = '0;
  logic [NCH-1:0]  en = '0;
  logic [4*NCH-1:0] level = '0;
  logic [NCH-1:0]  ina1, ina2, inb1, inb2, stanby, vref;
  logic [1:0]      mode;
  logic            tick;
  logic [3*NCH-1:0] phase_idx;

  int errors = 0;
  int checks = 0;

  stepper_seq_multi #(
    .NUM_CH(NCH), .PERIOD_W(PW), .DEBOUNCE(DB), .MODE_RESET(2'd2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_mode_n(sw_mode_n), .mode_wr(mode_wr),
    .mode_wdata(mode_wdata), .period_i(period), .dir_i(dir), .enable_i(en),
    .vref_level_i(level), .ina1_o(ina1), .ina2_o(ina2), .inb1_o(inb1), .inb2_o(inb2),
    .stanby_o(stanby), .vref_o(vref), .mode_o(mode), .step_tick_o(tick),
    .phase_idx_o(phase_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] dir;
    logic [1:0] en;
    logic [2:0] idx0;
    logic [2:0] idx1;
    logic [3:0] coil0;
    logic [3:0] coil1;
    logic [1:0] stby;
  } vec_t;

  vec_t vecs [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] coil(input int c);
    return {ina1[c], ina2[c], inb1[c], inb2[c]};
  endfunction

  function automatic logic [2:0] idx(input int c);
    return phase_idx[3*c +: 3];
  endfunction

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < 20);
    chk("tick_seen", 32'(tick), 32'd1);
  endtask

  task automatic count_vref(output int h0, output int h1);
    h0 = 0;
    h1 = 0;
    for (int k = 0; k < 16; k++) begin
      h0 += int'(vref[0]);
      h1 += int'(vref[1]);
      step();
    end
  endtask

  initial begin
    int n;
    int h0, h1;

    //             dir    en     idx0  idx1  coil0    coil1    stby
    vecs[0]  = '{2'b11, 2'b11, 3'd1, 3'd1, 4'b1010, 4'b1010, 2'b11};
    vecs[1]  = '{2'b11, 2'b11, 3'd2, 3'd2, 4'b0010, 4'b0010, 2'b11};
    vecs[2]  = '{2'b11, 2'b11, 3'd3, 3'd3, 4'b0110, 4'b0110, 2'b11};
    vecs[3]  = '{2'b11, 2'b11, 3'd4, 3'd4, 4'b0100, 4'b0100, 2'b11};
    vecs[4]  = '{2'b11, 2'b11, 3'd5, 3'd5, 4'b0101, 4'b0101, 2'b11};
    vecs[5]  = '{2'b11, 2'b11, 3'd6, 3'd6, 4'b0001, 4'b0001, 2'b11};
    vecs[6]  = '{2'b11, 2'b11, 3'd7, 3'd7, 4'b1001, 4'b1001, 2'b11};
    vecs[7]  = '{2'b11, 2'b11, 3'd0, 3'd0, 4'b1000, 4'b1000, 2'b11};
    vecs[8]  = '{2'b01, 2'b11, 3'd1, 3'd7, 4'b1010, 4'b1001, 2'b11};
    vecs[9]  = '{2'b01, 2'b01, 3'd2, 3'd7, 4'b0010, 4'b0000, 2'b01};
    vecs[10] = '{2'b00, 2'b10, 3'd2, 3'd6, 4'b0000, 4'b0001, 2'b10};
    vecs[11] = '{2'b10, 2'b10, 3'd2, 3'd7, 4'b0000, 4'b1001, 2'b10};

    // Reset state
    step();
    step();
    chk("rst_idx", 32'(phase_idx), 32'd0);
    chk("rst_coils", 32'({ina1, ina2, inb1, inb2}), 32'd0);
    chk("rst_stanby", 32'(stanby), 32'd0);
    chk("rst_vref", 32'(vref), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_mode", 32'(mode), 32'd2);
    rst_n = 1'b1;
    step();

    // Half-step table, period 10
    period = 8'd10;
    for (int i = 0; i < 12; i++) begin
      dir = vecs[i].dir;
      en  = vecs[i].en;
      wait_tick(n);
      if (i > 0) chk("tick_spacing", 32'(n), 32'd9);
      chk("vec_idx0", 32'(idx(0)), 32'(vecs[i].idx0));
      chk("vec_idx1", 32'(idx(1)), 32'(vecs[i].idx1));
      step();
      chk("vec_coil0", 32'(coil(0)), 32'(vecs[i].coil0));
      chk("vec_coil1", 32'(coil(1)), 32'(vecs[i].coil1));
      chk("vec_stanby", 32'(stanby), 32'(vecs[i].stby));
    end

    // Host write to full mode mid-period applies only on the next tick
    en  = 2'b11;
    dir = 2'b11;
    step();
    step();
    mode_wr = 1'b1;
    mode_wdata = 2'd1;
    step();
    mode_wr = 1'b0;
    step();
    chk("mode_hold_until_tick", 32'(mode), 32'd2);
    wait_tick(n);
    chk("full_mode", 32'(mode), 32'd1);
    chk("full_idx0_a", 32'(idx(0)), 32'd5);
    chk("full_idx1_a", 32'(idx(1)), 32'd1);
    step();
    chk("full_coil0", 32'(coil(0)), 32'b0101);
    chk("full_coil1", 32'(coil(1)), 32'b1010);
    wait_tick(n);
    chk("full_idx0_b", 32'(idx(0)), 32'd7);
    chk("full_idx1_b", 32'(idx(1)), 32'd3);
    wait_tick(n);
    chk("full_idx0_c", 32'(idx(0)), 32'd1);
    chk("full_idx1_c", 32'(idx(1)), 32'd5);

    // Button bounce with timer stopped: only a long press counts, once
    period = '0;
    step();
    for (int g = 0; g < 5; g++) begin
      sw_mode_n = 1'b0;
      step();
      step();
      sw_mode_n = 1'b1;
      repeat (3) step();
    end
    repeat (4) step();
    chk("bounce_no_press", 32'(mode), 32'd1);
    sw_mode_n = 1'b0;
    repeat (3*DB) step();
    chk("press_once", 32'(mode), 32'd2);
    sw_mode_n = 1'b1;
    repeat (3*DB) step();
    chk("release_no_press", 32'(mode), 32'd2);

    mode_wr = 1'b1;
    mode_wdata = 2'd0;
    step();
    mode_wr = 1'b0;
    step();
    chk("wr_period0", 32'(mode), 32'd0);

    // Host write collides with debounced press; timer restarted with period 10
    sw_mode_n = 1'b0;
    period = 8'd10;
    repeat (DB + 2) step();
    mode_wr = 1'b1;
    mode_wdata = 2'd3;
    step();
    mode_wr = 1'b0;
    chk("stby_before_tick", 32'(mode), 32'd0);
    wait_tick(n);
    chk("stby_mode", 32'(mode), 32'd3);
    chk("stby_idx_frozen", 32'(phase_idx), 32'({3'd5, 3'd1}));
    step();
    chk("stby_coils", 32'({ina1, ina2, inb1, inb2}), 32'd0);
    chk("stby_stanby", 32'(stanby), 32'd0);
    wait_tick(n);
    chk("stby_idx_still", 32'(phase_idx), 32'({3'd5, 3'd1}));
    chk("stby_mode_kept", 32'(mode), 32'd3);
    sw_mode_n = 1'b1;
    repeat (3*DB) step();

    // Period shrink below the running count ticks on the next cycle
    en  = 2'b01;
    dir = 2'b00;
    mode_wr = 1'b1;
    mode_wdata = 2'd2;
    step();
    mode_wr = 1'b0;
    wait_tick(n);
    chk("shrink_mode", 32'(mode), 32'd2);
    chk("shrink_idx0_a", 32'(idx(0)), 32'd0);
    chk("shrink_idx1_held", 32'(idx(1)), 32'd5);
    repeat (7) step();
    chk("no_tick_at_cnt7", 32'(tick), 32'd0);
    period = 8'd3;
    step();
    chk("shrink_tick", 32'(tick), 32'd1);
    chk("shrink_idx0_wrap", 32'(idx(0)), 32'd7);
    step();
    chk("shrink_coil0", 32'(coil(0)), 32'b1001);
    chk("shrink_coil1", 32'(coil(1)), 32'b0000);
    chk("shrink_stanby", 32'(stanby), 32'b01);
    step();
    step();
    chk("period3_tick", 32'(tick), 32'd1);
    chk("period3_idx0", 32'(idx(0)), 32'd6);

    // VREF levels: ch0 active, ch1 disabled
    level = {4'd4, 4'd4};
    step();
    count_vref(h0, h1);
    chk("vref_lvl4_ch0", 32'(h0), 32'(VREF4_HIGH));
    chk("vref_disabled_ch1", 32'(h1), 32'd0);
    level = {4'd4, 4'd0};
    step();
    count_vref(h0, h1);
    chk("vref_lvl0_ch0", 32'(h0), 32'd0);
`ifdef STEPPER_VREF_PWM_EN
    level = {4'd0, 4'd15};
    step();
    count_vref(h0, h1);
    chk("vref_lvl15_ch0", 32'(h0), 32'd15);
`endif

    // Asynchronous reset in the middle of a cycle
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_idx", 32'(phase_idx), 32'd0);
    chk("arst_coils", 32'({ina1, ina2, inb1, inb2}), 32'd0);
    chk("arst_stanby_vref", 32'({stanby, vref}), 32'd0);
    chk("arst_tick", 32'(tick), 32'd0);
    chk("arst_mode", 32'(mode), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
